// File: rtl/sobolrng_multi.sv
// sobolrng_multi
// Multi-dimension Sobol low-discrepancy sequence generator. NDIM streams of
// BITWIDTH-bit samples advance together from one shared index counter. Every
// direction vector and a per-dimension digital-shift seed can be rewritten
// at run time through the write port.
//
// Ports
//   iClk     clock, rising edge
//   iRstN    asynchronous active-low reset
//   iEn      advance the sequence by one index
//   iClr     synchronous restart of index and states (priority over iEn)
//   iWrEn    write strobe
//   iWrDim   target dimension
//   iWrIdx   0..BITWIDTH-1 selects direction vector v[idx], BITWIDTH the seed
//   iWrData  write value
//   oRand    dimension d sample on [d*BITWIDTH +: BITWIDTH]
//   oIdx     current sequence index
//   oWrap    one-cycle pulse after a full period completes
module sobolrng_multi #(
    parameter int BITWIDTH = 8,
    parameter int NDIM     = 2,
    localparam int DIM_W   = (NDIM > 1) ? $clog2(NDIM) : 1,
    localparam int IDX_W   = $clog2(BITWIDTH + 1)
) (
    input  logic                     iClk,
    input  logic                     iRstN,
    input  logic                     iEn,
    input  logic                     iClr,
    input  logic                     iWrEn,
    input  logic [DIM_W-1:0]         iWrDim,
    input  logic [IDX_W-1:0]         iWrIdx,
    input  logic [BITWIDTH-1:0]      iWrData,
    output logic [NDIM*BITWIDTH-1:0] oRand,
    output logic [BITWIDTH-1:0]      oIdx,
    output logic                     oWrap
);

    logic [BITWIDTH-1:0] cnt;
    logic                wrap;
    logic [BITWIDTH-1:0] state    [NDIM];
    logic [BITWIDTH-1:0] shift    [NDIM];
    logic [BITWIDTH-1:0] vec      [NDIM][BITWIDTH];
    logic [BITWIDTH-1:0] step_vec [NDIM];
    logic [BITWIDTH-1:0] lsz_1h;
    logic                all_ones;

    // Reset direction vectors: dimension 0 is van der Corput, every other
    // dimension starts as Sobol dimension 2.
    function automatic logic [BITWIDTH-1:0] default_vec(input int d, input int k);
        logic [BITWIDTH-1:0] v;
        v = {1'b1, {(BITWIDTH-1){1'b0}}};
        if (d == 0) begin
            v = v >> k;
        end else begin
            for (int i = 1; i < BITWIDTH; i++) begin
                if (i <= k) v = v ^ (v >> 1);
            end
        end
        return v;
    endfunction

    // ~n & (n+1) isolates the least-significant zero bit of n as a one-hot
    // mask; it is all-zero at the wrap index, where no vector is used.
    always_comb begin
        lsz_1h   = ~cnt & (cnt + 1'b1);
        all_ones = &cnt;
        for (int d = 0; d < NDIM; d++) begin
            step_vec[d] = '0;
            for (int k = 0; k < BITWIDTH; k++) begin
                if (lsz_1h[k]) step_vec[d] = step_vec[d] | vec[d][k];
            end
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            cnt  <= '0;
            wrap <= 1'b0;
            for (int d = 0; d < NDIM; d++) begin
                state[d] <= '0;
                shift[d] <= '0;
                for (int k = 0; k < BITWIDTH; k++) begin
                    vec[d][k] <= default_vec(d, k);
                end
            end
        end else begin
            wrap <= 1'b0;
            if (iClr) begin
                cnt <= '0;
                for (int d = 0; d < NDIM; d++) state[d] <= '0;
            end else if (iEn) begin
                cnt <= cnt + 1'b1;
                if (all_ones) begin
                    wrap <= 1'b1;
                    for (int d = 0; d < NDIM; d++) state[d] <= '0;
                end else begin
                    for (int d = 0; d < NDIM; d++) state[d] <= state[d] ^ step_vec[d];
                end
            end
            // Advance above reads step_vec from the current vectors, so a write
            // in the same cycle only affects later updates. Out-of-range
            // dimension or index codes match no target and are dropped.
            if (iWrEn) begin
                for (int d = 0; d < NDIM; d++) begin
                    if (iWrDim == DIM_W'(d)) begin
                        for (int k = 0; k < BITWIDTH; k++) begin
                            if (iWrIdx == IDX_W'(k)) vec[d][k] <= iWrData;
                        end
                        if (iWrIdx == IDX_W'(BITWIDTH)) shift[d] <= iWrData;
                    end
                end
            end
        end
    end

    always_comb begin
        oRand = '0;
        for (int d = 0; d < NDIM; d++) begin
            oRand[d*BITWIDTH +: BITWIDTH] = state[d] ^ shift[d];
        end
    end

    assign oIdx  = cnt;
    assign oWrap = wrap;

endmodule

// File: tb/tb_sobolrng_multi.sv
module tb_sobolrng_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en, clr, wr_en, wr_dim;
    logic [3:0]  wr_idx;
    logic [7:0]  wr_data;
    logic [15:0] rand8;
    logic [7:0]  idx8;
    logic        wrap8;

    logic        en4, clr4, wr_en4, wr_dim4;
    logic [2:0]  wr_idx4;
    logic [3:0]  wr_data4;
    logic [3:0]  rand4;
    logic [3:0]  idx4;
    logic        wrap4;

    sobolrng_multi #(.BITWIDTH(8), .NDIM(2)) u_dut8 (
        .iClk(clk), .iRstN(rst_n), .iEn(en), .iClr(clr), .iWrEn(wr_en),
        .iWrDim(wr_dim), .iWrIdx(wr_idx), .iWrData(wr_data),
        .oRand(rand8), .oIdx(idx8), .oWrap(wrap8)
    );

    sobolrng_multi #(.BITWIDTH(4), .NDIM(1)) u_dut4 (
        .iClk(clk), .iRstN(rst_n), .iEn(en4), .iClr(clr4), .iWrEn(wr_en4),
        .iWrDim(wr_dim4), .iWrIdx(wr_idx4), .iWrData(wr_data4),
        .oRand(rand4), .oIdx(idx4), .oWrap(wrap4)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference: with fixed vectors and state cleared at index 0, the sample
    // at index n is the XOR of the vectors selected by the Gray code of n.
    logic [7:0] mv  [2][8];
    logic [7:0] ms  [2];
    logic [3:0] mv4 [4];

    function automatic void model_reset();
        logic [7:0] v;
        v = 8'h80;
        for (int k = 0; k < 8; k++) begin
            mv[0][k] = 8'h80 >> k;
            mv[1][k] = v;
            v = v ^ (v >> 1);
        end
        for (int k = 0; k < 4; k++) mv4[k] = 4'h8 >> k;
        ms[0] = 8'h00;
        ms[1] = 8'h00;
    endfunction

    function automatic logic [7:0] sob8(input int d, input int n);
        int g;
        logic [7:0] r;
        g = n ^ (n >> 1);
        r = 8'h00;
        for (int k = 0; k < 8; k++) if (g[k]) r = r ^ mv[d][k];
        return r ^ ms[d];
    endfunction

    function automatic logic [3:0] sob4(input int n);
        int g;
        logic [3:0] r;
        g = n ^ (n >> 1);
        r = 4'h0;
        for (int k = 0; k < 4; k++) if (g[k]) r = r ^ mv4[k];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear8();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 0; clr = 0; wr_en = 0; wr_dim = 0; wr_idx = 0; wr_data = 0;
        en4 = 0; clr4 = 0; wr_en4 = 0; wr_dim4 = 0; wr_idx4 = 0; wr_data4 = 0;
        model_reset();
        #22;
        rst_n = 1'b1;
        tick();
        n_total++; if (rand8 !== 16'h0) $display("FAIL reset_rand8 got %h want 0000", rand8); else n_pass++;
        n_total++; if (idx8 !== 8'h0) $display("FAIL reset_idx8 got %0d want 0", idx8); else n_pass++;
        n_total++; if (wrap8 !== 1'b0) $display("FAIL reset_wrap8 got %b want 0", wrap8); else n_pass++;
        n_total++; if (rand4 !== 4'h0 || idx4 !== 4'h0) $display("FAIL reset_dut4 got rand=%h idx=%0d want 0/0", rand4, idx4); else n_pass++;
    endtask

    task automatic test_default_seq();
        logic [7:0] exp0 [9];
        exp0 = '{8'd0, 8'd128, 8'd192, 8'd64, 8'd96, 8'd224, 8'd160, 8'd32, 8'd48};
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) tick();
            n_total++; if (rand8[7:0] !== exp0[i]) $display("FAIL seq_dim0[%0d] got %0d want %0d", i, rand8[7:0], exp0[i]); else n_pass++;
            n_total++; if (rand8[15:8] !== sob8(1, i)) $display("FAIL seq_dim1[%0d] got %0d want %0d", i, rand8[15:8], sob8(1, i)); else n_pass++;
            n_total++; if (idx8 !== 8'(i)) $display("FAIL seq_idx[%0d] got %0d want %0d", i, idx8, i); else n_pass++;
            en = 1'b1;
        end
        en = 1'b0;
        clear8();
    endtask

    task automatic test_full_period4();
        logic seen [16];
        int   n_seen;
        for (int i = 0; i < 16; i++) seen[i] = 1'b0;
        seen[rand4] = 1'b1;
        en4 = 1'b1;
        for (int i = 1; i < 16; i++) begin
            tick();
            n_total++; if (rand4 !== sob4(i) || idx4 !== 4'(i)) $display("FAIL p4_step[%0d] got rand=%0d idx=%0d want %0d/%0d", i, rand4, idx4, sob4(i), i); else n_pass++;
            n_total++; if (wrap4 !== 1'b0) $display("FAIL p4_nowrap[%0d] got %b want 0", i, wrap4); else n_pass++;
            seen[rand4] = 1'b1;
        end
        n_seen = 0;
        for (int i = 0; i < 16; i++) if (seen[i]) n_seen++;
        n_total++; if (n_seen != 16) $display("FAIL p4_coverage got %0d distinct want 16", n_seen); else n_pass++;
        tick();
        n_total++; if (idx4 !== 4'h0 || rand4 !== 4'h0) $display("FAIL p4_wrap_state got idx=%0d rand=%0d want 0/0", idx4, rand4); else n_pass++;
        n_total++; if (wrap4 !== 1'b1) $display("FAIL p4_wrap_pulse got %b want 1", wrap4); else n_pass++;
        tick();
        n_total++; if (wrap4 !== 1'b0 || idx4 !== 4'h1 || rand4 !== 4'h8) $display("FAIL p4_after_wrap got wrap=%b idx=%0d rand=%0d want 0/1/8", wrap4, idx4, rand4); else n_pass++;
        en4 = 1'b0;
        clr4 = 1'b1; tick(); clr4 = 1'b0;
    endtask

    task automatic test_seed();
        wr_en = 1'b1; wr_dim = 1'b1; wr_idx = 4'd8; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        ms[1] = 8'hA5;
        n_total++; if (rand8 !== 16'hA500) $display("FAIL seed_idle got %h want a500", rand8); else n_pass++;
        en = 1'b1;
        tick();
        en = 1'b0;
        n_total++; if (rand8 !== 16'h2580) $display("FAIL seed_advance got %h want 2580", rand8); else n_pass++;
        clr = 1'b1; wr_en = 1'b1; wr_dim = 1'b1; wr_idx = 4'd8; wr_data = 8'h00;
        tick();
        clr = 1'b0; wr_en = 1'b0;
        ms[1] = 8'h00;
        n_total++; if (rand8 !== 16'h0 || idx8 !== 8'h0) $display("FAIL seed_restore got rand=%h idx=%0d want 0000/0", rand8, idx8); else n_pass++;
    endtask

    task automatic test_write_advance();
        en = 1'b1; wr_en = 1'b1; wr_dim = 1'b0; wr_idx = 4'd0; wr_data = 8'h01;
        tick();
        wr_en = 1'b0;
        n_total++; if (rand8[7:0] !== 8'd128 || idx8 !== 8'd1) $display("FAIL wradv_old_vec got %0d idx=%0d want 128/1", rand8[7:0], idx8); else n_pass++;
        tick();
        tick();
        en = 1'b0;
        n_total++; if (rand8[7:0] !== 8'hC1 || idx8 !== 8'd3) $display("FAIL wradv_new_vec got %h idx=%0d want c1/3", rand8[7:0], idx8); else n_pass++;
        clr = 1'b1; wr_en = 1'b1; wr_dim = 1'b0; wr_idx = 4'd0; wr_data = 8'h80;
        tick();
        clr = 1'b0; wr_en = 1'b0;
    endtask

    task automatic test_clear();
        en = 1'b1;
        repeat (5) tick();
        n_total++; if (idx8 !== 8'd5) $display("FAIL clr_pre_idx got %0d want 5", idx8); else n_pass++;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_total++; if (idx8 !== 8'd0 || rand8 !== 16'h0 || wrap8 !== 1'b0) $display("FAIL clr_state got idx=%0d rand=%h wrap=%b want 0/0000/0", idx8, rand8, wrap8); else n_pass++;
        tick();
        en = 1'b0;
        n_total++; if (rand8 !== 16'h8080 || idx8 !== 8'd1) $display("FAIL clr_vectors_kept got rand=%h idx=%0d want 8080/1", rand8, idx8); else n_pass++;
        clear8();
    endtask

    task automatic test_reset_mid();
        wr_en = 1'b1; wr_dim = 1'b1; wr_idx = 4'd2; wr_data = 8'h3C;
        tick();
        wr_en = 1'b0;
        en = 1'b1;
        repeat (4) tick();
        @(posedge clk);
        #3;
        en = 1'b0;
        rst_n = 1'b0;
        #1;
        n_total++; if (rand8 !== 16'h0 || idx8 !== 8'h0 || wrap8 !== 1'b0) $display("FAIL rstmid_async got rand=%h idx=%0d wrap=%b want 0000/0/0", rand8, idx8, wrap8); else n_pass++;
        #3;
        rst_n = 1'b1;
        model_reset();
        tick();
        en = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            n_total++; if (rand8[15:8] !== sob8(1, i)) $display("FAIL rstmid_dim1[%0d] got %0d want %0d", i, rand8[15:8], sob8(1, i)); else n_pass++;
        end
        en = 1'b0;
        clear8();
    endtask

    task automatic test_invalid_write();
        wr_en4 = 1'b1; wr_dim4 = 1'b1; wr_idx4 = 3'd0; wr_data4 = 4'hF;
        tick();
        wr_dim4 = 1'b1; wr_idx4 = 3'd4;
        tick();
        wr_dim4 = 1'b0; wr_idx4 = 3'd5;
        tick();
        wr_en4 = 1'b0;
        n_total++; if (rand4 !== 4'h0 || idx4 !== 4'h0) $display("FAIL inval_idle got rand=%0d idx=%0d want 0/0", rand4, idx4); else n_pass++;
        en4 = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_total++; if (rand4 !== sob4(i)) $display("FAIL inval_seq[%0d] got %0d want %0d", i, rand4, sob4(i)); else n_pass++;
        end
        en4 = 1'b0;
        clr4 = 1'b1; tick(); clr4 = 1'b0;
    endtask

    task automatic test_random();
        int n, exp_wrap, wraps_dut, wraps_model, d, ix, errs;
        logic [7:0] data;
        for (int i = 0; i < 14; i++) begin
            d    = $urandom_range(0, 1);
            ix   = $urandom_range(0, 15);
            data = 8'($urandom);
            wr_en = 1'b1; wr_dim = 1'(d); wr_idx = 4'(ix); wr_data = data;
            tick();
            wr_en = 1'b0;
            if (ix < 8) mv[d][ix] = data;
            else if (ix == 8) ms[d] = data;
        end
        clear8();
        n = 0; exp_wrap = 0; wraps_dut = 0; wraps_model = 0; errs = 0;
        for (int i = 0; i < 700; i++) begin
            en  = ($urandom_range(0, 3) != 0);
            clr = (i < 100) && ($urandom_range(0, 29) == 0);
            tick();
            if (clr) begin
                n = 0; exp_wrap = 0;
            end else if (en) begin
                exp_wrap = (n == 255) ? 1 : 0;
                n = (n + 1) % 256;
            end else begin
                exp_wrap = 0;
            end
            wraps_model += exp_wrap;
            if (wrap8) wraps_dut++;
            n_total++;
            if (rand8 !== {sob8(1, n), sob8(0, n)} || idx8 !== 8'(n) || wrap8 !== 1'(exp_wrap)) begin
                errs++;
                if (errs <= 10) $display("FAIL rand_step[%0d] got rand=%h idx=%0d wrap=%b want %h/%0d/%0d", i, rand8, idx8, wrap8, {sob8(1, n), sob8(0, n)}, n, exp_wrap);
            end else n_pass++;
        end
        en = 1'b0; clr = 1'b0;
        n_total++; if (wraps_dut != wraps_model || wraps_model == 0) $display("FAIL rand_wraps got %0d want %0d (nonzero)", wraps_dut, wraps_model); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_default_seq();
        test_full_period4();
        test_seed();
        test_write_advance();
        test_clear();
        test_reset_mid();
        test_invalid_write();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout after %0d checks", n_total);
        $fatal(1, "timeout");
    end

endmodule
